model_clock_sequencer: RTL



---
 rtl/model_clock_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/model_clock_sequencer.sv
// rtl/model_clock_sequencer.sv - programmable 50%-duty model clock with run/pause/step/burst modes
// Divided clock, rising-edge tick and edge counter; all outputs registered.
module model_clock_sequencer #(
  parameter int unsigned        DIV_W       = 28,
  parameter logic [DIV_W-1:0]   DEFAULT_DIV = DIV_W'(33554431),
  parameter int unsigned        BURST_W     = 8,
  parameter int unsigned        CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic               cfg_load,
  input  logic [1:0]         mode,
  input  logic               step,
  input  logic [BURST_W-1:0] burst_len,
  output logic               clk_out,
  output logic               tick,
  output logic               busy,
  output logic [CNT_W-1:0]   edge_count
);

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_PAUSE = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic               clk_out_q, clk_out_d;
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   edge_count_q, edge_count_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [1:0]         prev_mode_q, prev_mode_d;

  logic mode_chg;
  logic seq_mode;
  logic cnt_en;
  logic start;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= DEFAULT_DIV;
      cnt_q        <= '0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      edge_count_q <= '0;
      rem_q        <= '0;
      prev_mode_q  <= MODE_RUN;
    end else begin
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
      edge_count_q <= edge_count_d;
      rem_q        <= rem_d;
      prev_mode_q  <= prev_mode_d;
    end
  end

  always_comb begin
    mode_chg = (mode != prev_mode_q);
    seq_mode = mode[1];
    cnt_en   = 1'b0;
    unique case (mode)
      MODE_RUN:   cnt_en = 1'b1;
      MODE_PAUSE: cnt_en = 1'b0;
      // Sequence modes count while a sequence runs or while finishing a high phase.
      default:    cnt_en = clk_out_q | (busy_q & ~mode_chg);
    endcase
    start = seq_mode & ~mode_chg & step & ~busy_q & ~clk_out_q &
            ((mode == MODE_STEP) | (burst_len != '0));
  end

  always_comb begin
    div_d        = div_q;
    cnt_d        = cnt_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    busy_d       = busy_q;
    edge_count_d = edge_count_q;
    rem_d        = rem_q;
    prev_mode_d  = mode;

    if (mode_chg) begin
      rem_d  = '0;
      busy_d = 1'b0;
    end

    if (cfg_load) begin
      div_d = cfg_div;
      cnt_d = '0;
    end else if (cnt_en) begin
      if (cnt_q == div_q) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
        if (!clk_out_q) begin
          tick_d       = 1'b1;
          edge_count_d = edge_count_q + CNT_W'(1);
        end else if (seq_mode && busy_q && !mode_chg) begin
          if (rem_q <= BURST_W'(1)) begin
            busy_d = 1'b0;
            rem_d  = '0;
          end else begin
            rem_d = rem_q - BURST_W'(1);
          end
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else if (seq_mode && mode_chg) begin
      cnt_d = '0;
    end

    // A single step is a burst of one period.
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = (mode == MODE_STEP) ? BURST_W'(1) : burst_len;
    end
  end

  assign clk_out    = clk_out_q;
  assign tick       = tick_q;
  assign busy       = busy_q;
  assign edge_count = edge_count_q;

endmodule
